audio_peak_tracker: RTL and testbench

Monitors the mixed audio sample stream and tracks the running positive peak and negative trough, with programmable hold and exponential decay toward zero. Feeds the status inputs sr_cir_max_amplitude and sr_cir_min_amplitude of the AXI register slave, and consumes its one-cycle cmd_cir_clear_max pulse. Also detects clipping against a register-controlled level and produces an IRQ pulse and a saturating clip counter. Passive tap: no back-pressure on the audio stream.

---
 rtl/audio_peak_tracker.sv | 148 ++++++++++++++
 tb/tb_audio_peak_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_peak_tracker.sv
// audio_peak_tracker
//   Passive tap on the mixed audio stream. Tracks the running positive peak
//   and negative trough of the signed samples. Each new extreme is held for
//   HOLD_SAMPLES_P valid samples and then decays exponentially toward zero.
//   Also counts clipped samples against a programmable magnitude.
//
// Ports
//   clk              clock
//   rst_n            asynchronous active-low reset
//   x_valid          sample strobe, one sample per high cycle
//   x_data           signed audio sample
//   cmd_clear        one-cycle clear pulse; wins over a same-cycle sample
//   cr_clip_level    unsigned clip magnitude, 0 disables clip detection
//   sr_max_amplitude running peak (>= 0)
//   sr_min_amplitude running trough (<= 0)
//   sr_clip_count    saturating clip event count
//   irq_clip         one-cycle pulse per clipped sample
module audio_peak_tracker #(
    parameter int AUDIO_WIDTH_P    = 24,
    parameter int HOLD_SAMPLES_P   = 48000,
    parameter int DECAY_SHIFT_P    = 4,
    parameter int CLIP_CNT_WIDTH_P = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               x_valid,
    input  logic signed [AUDIO_WIDTH_P-1:0]    x_data,
    input  logic                               cmd_clear,
    input  logic        [AUDIO_WIDTH_P-2:0]    cr_clip_level,
    output logic signed [AUDIO_WIDTH_P-1:0]    sr_max_amplitude,
    output logic signed [AUDIO_WIDTH_P-1:0]    sr_min_amplitude,
    output logic        [CLIP_CNT_WIDTH_P-1:0] sr_clip_count,
    output logic                               irq_clip
);

    localparam int W  = AUDIO_WIDTH_P;
    localparam int HW = (HOLD_SAMPLES_P > 0) ? $clog2(HOLD_SAMPLES_P + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_SAMPLES_P);

    logic signed [W-1:0]             r_max;
    logic signed [W-1:0]             r_min;
    logic        [HW-1:0]            r_hold_max;
    logic        [HW-1:0]            r_hold_min;
    logic        [CLIP_CNT_WIDTH_P-1:0] r_clip_count;
    logic                            r_irq;

    logic signed [W-1:0]  w_max_step;
    logic signed [W-1:0]  w_max_dec;
    logic signed [W:0]    w_min_mag;
    logic        [W-1:0]  w_min_step;
    logic signed [W-1:0]  w_min_inc;
    logic signed [W-1:0]  w_max_next;
    logic signed [W-1:0]  w_min_next;
    logic        [HW-1:0] w_hold_max_next;
    logic        [HW-1:0] w_hold_min_next;
    logic        [W-1:0]  w_x_abs;
    logic                 w_clip;

    // Decay arithmetic. r_max is never negative, so the arithmetic shift is
    // a plain magnitude shift; the step is forced to 1 so small peaks still
    // reach exactly zero instead of stalling.
    always_comb begin
        w_max_step = r_max >>> DECAY_SHIFT_P;
        if (w_max_step == '0 && r_max > 0)
            w_max_step = W'(1);
        w_max_dec = r_max - w_max_step;
    end

    // The trough magnitude needs W+1 bits so that -2^(W-1) is representable.
    // With a shift of at least 1 the step always fits in W bits and stays
    // below |r_min|, so r_min + step lands in [r_min, 0] without overflow.
    always_comb begin
        w_min_mag  = -{r_min[W-1], r_min};
        w_min_step = W'(w_min_mag >> DECAY_SHIFT_P);
        if (w_min_step == '0 && r_min < 0)
            w_min_step = W'(1);
        w_min_inc = r_min + $signed(w_min_step);
    end

    always_comb begin
        w_max_next      = r_max;
        w_hold_max_next = r_hold_max;
        if (x_data > r_max) begin
            w_max_next      = x_data;
            w_hold_max_next = HOLD_LOAD;
        end else if (r_hold_max != '0) begin
            w_hold_max_next = r_hold_max - HW'(1);
        end else if (HOLD_SAMPLES_P != 0) begin
            // w_max_dec >= 0, so taking the larger with x_data keeps the
            // peak from crossing zero.
            w_max_next = (x_data > w_max_dec) ? x_data : w_max_dec;
        end
    end

    always_comb begin
        w_min_next      = r_min;
        w_hold_min_next = r_hold_min;
        if (x_data < r_min) begin
            w_min_next      = x_data;
            w_hold_min_next = HOLD_LOAD;
        end else if (r_hold_min != '0) begin
            w_hold_min_next = r_hold_min - HW'(1);
        end else if (HOLD_SAMPLES_P != 0) begin
            w_min_next = (x_data < w_min_inc) ? x_data : w_min_inc;
        end
    end

    // |x| in W unsigned bits: the most negative sample maps to 2^(W-1).
    always_comb begin
        w_x_abs = x_data[W-1] ? $unsigned(-x_data) : $unsigned(x_data);
        w_clip  = x_valid && (cr_clip_level != '0) &&
                  (w_x_abs >= {1'b0, cr_clip_level});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max        <= '0;
            r_min        <= '0;
            r_hold_max   <= '0;
            r_hold_min   <= '0;
            r_clip_count <= '0;
            r_irq        <= 1'b0;
        end else if (cmd_clear) begin
            r_max        <= '0;
            r_min        <= '0;
            r_hold_max   <= '0;
            r_hold_min   <= '0;
            r_clip_count <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_irq <= w_clip;
            if (x_valid) begin
                r_max      <= w_max_next;
                r_min      <= w_min_next;
                r_hold_max <= w_hold_max_next;
                r_hold_min <= w_hold_min_next;
            end
            if (w_clip && r_clip_count != '1)
                r_clip_count <= r_clip_count + CLIP_CNT_WIDTH_P'(1);
        end
    end

    assign sr_max_amplitude = r_max;
    assign sr_min_amplitude = r_min;
    assign sr_clip_count    = r_clip_count;
    assign irq_clip         = r_irq;

endmodule

// File: tb/tb_audio_peak_tracker.sv
module tb_audio_peak_tracker;

    localparam int W     = 24;
    localparam int HOLD  = 4;
    localparam int SHIFT = 2;
    localparam int CW    = 16;
    localparam longint CNT_MAX = (longint'(1) << CW) - 1;
    localparam longint DIV     = longint'(1) << SHIFT;

    logic                  clk;
    logic                  rst_n;
    logic                  x_valid;
    logic signed [W-1:0]   x_data;
    logic                  cmd_clear;
    logic        [W-2:0]   cr_clip_level;
    logic signed [W-1:0]   sr_max_amplitude;
    logic signed [W-1:0]   sr_min_amplitude;
    logic        [CW-1:0]  sr_clip_count;
    logic                  irq_clip;

    audio_peak_tracker #(
        .AUDIO_WIDTH_P   (W),
        .HOLD_SAMPLES_P  (HOLD),
        .DECAY_SHIFT_P   (SHIFT),
        .CLIP_CNT_WIDTH_P(CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .x_valid         (x_valid),
        .x_data          (x_data),
        .cmd_clear       (cmd_clear),
        .cr_clip_level   (cr_clip_level),
        .sr_max_amplitude(sr_max_amplitude),
        .sr_min_amplitude(sr_min_amplitude),
        .sr_clip_count   (sr_clip_count),
        .irq_clip        (irq_clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint mx;
        longint mn;
        longint cnt;
        bit     irq;
    } exp_t;

    exp_t   sb_q[$];
    int     n_assert = 0;
    int     n_fail   = 0;

    // Reference model state, plain integers.
    longint m_max, m_min, m_cnt;
    int     m_hmax, m_hmin;
    bit     m_irq;
    logic [W-2:0] lvl;

    task automatic model_reset();
        m_max = 0; m_min = 0; m_cnt = 0; m_hmax = 0; m_hmin = 0; m_irq = 0;
    endtask

    function automatic longint max3(longint a, longint b, longint c);
        longint r;
        r = a;
        if (b > r) r = b;
        if (c > r) r = c;
        return r;
    endfunction

    function automatic longint min3(longint a, longint b, longint c);
        longint r;
        r = a;
        if (b < r) r = b;
        if (c < r) r = c;
        return r;
    endfunction

    task automatic model_step(input bit v, input longint d, input bit clr, input longint level);
        longint step, mag, a;
        if (clr) begin
            model_reset();
            return;
        end
        m_irq = 0;
        if (!v) return;
        if (d > m_max) begin
            m_max = d; m_hmax = HOLD;
        end else if (m_hmax > 0) begin
            m_hmax--;
        end else if (HOLD != 0) begin
            step = m_max / DIV;
            if (step == 0 && m_max > 0) step = 1;
            m_max = max3(m_max - step, d, 0);
        end
        if (d < m_min) begin
            m_min = d; m_hmin = HOLD;
        end else if (m_hmin > 0) begin
            m_hmin--;
        end else if (HOLD != 0) begin
            mag  = -m_min;
            step = mag / DIV;
            if (step == 0 && m_min < 0) step = 1;
            m_min = min3(m_min + step, d, 0);
        end
        a = (d < 0) ? -d : d;
        if (level != 0 && a >= level) begin
            m_irq = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    task automatic drive(input bit v, input logic signed [W-1:0] d, input bit clr);
        exp_t e;
        @(negedge clk);
        x_valid       = v;
        x_data        = d;
        cmd_clear     = clr;
        cr_clip_level = lvl;
        model_step(v, longint'(d), clr, longint'(lvl));
        e.mx = m_max; e.mn = m_min; e.cnt = m_cnt; e.irq = m_irq;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(posedge clk);
            #2;
            k++;
        end
        n_assert++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: outputs are registered, so one expected entry per driven cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_assert++;
            if (longint'(sr_max_amplitude) != e.mx || longint'(sr_min_amplitude) != e.mn ||
                longint'(sr_clip_count) != e.cnt || irq_clip != e.irq) begin
                n_fail++;
                $display("FAIL out_chk t=%0t max=%0d/%0d min=%0d/%0d cnt=%0d/%0d irq=%0b/%0b (actual/required)",
                         $time, sr_max_amplitude, e.mx, sr_min_amplitude, e.mn,
                         sr_clip_count, e.cnt, irq_clip, e.irq);
            end
        end
    end

    task automatic check_zero(input string name);
        n_assert++;
        if (sr_max_amplitude != 0 || sr_min_amplitude != 0 || sr_clip_count != 0 || irq_clip != 0) begin
            n_fail++;
            $display("FAIL %s max=%0d min=%0d cnt=%0d irq=%0b required all 0",
                     name, sr_max_amplitude, sr_min_amplitude, sr_clip_count, irq_clip);
        end
    endtask

    initial begin
        logic signed [W-1:0] d;
        int sel;
        rst_n = 1'b0; x_valid = 1'b0; x_data = '0; cmd_clear = 1'b0;
        lvl = 23'd1000; cr_clip_level = lvl;
        model_reset();
        #2;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: idle cycles
        repeat (10) drive(0, 0, 0);

        // 2: basic tracking
        drive(1, 100, 0); drive(1, 50, 0); drive(1, -30, 0); drive(1, 200, 0);

        // 3: hold then decay with gaps
        for (int i = 0; i < 14; i++) begin
            drive(1, 0, 0);
            if (i % 3 == 1) begin drive(0, 0, 0); drive(0, 0, 0); end
        end
        repeat (10) drive(1, 0, 0);

        // 4: clip detection
        drive(1, 999, 0); drive(1, 1000, 0); drive(1, -1000, 0);
        drive(1, -24'sd8388608, 0);
        lvl = '0;
        drive(1, 24'sd8388607, 0);
        lvl = 23'd1000;

        // 5: clear beats a same-cycle clipping sample
        drive(1, 5000, 1);
        drive(1, 10, 0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                sel = $urandom_range(0, 2);
                lvl = (sel == 0) ? '0 : (sel == 1) ? 23'd1000 : 23'($urandom_range(1, 8388607));
            end
            sel = $urandom_range(0, 3);
            case (sel)
                0: d = W'($urandom_range(0, 600)) - W'(300);
                1: d = W'($urandom);
                2: d = '0;
                default: d = ($urandom_range(0, 1) == 1) ? 24'sd8388607 : -24'sd8388608;
            endcase
            drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 49) == 0);
        end
        drain();

        // 6: saturation of the clip counter
        lvl = 23'd1000;
        drive(0, 0, 1);
        repeat (65535) drive(1, 5000, 0);
        drive(1, -5000, 0);
        drive(0, 0, 0);
        drain();

        // Async reset in the middle of a hold phase
        drive(1, 300, 0);
        drive(1, -300, 0);
        drive(1, 0, 0);
        drain();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset_mid_hold");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0); drive(1, 0, 0);
        drive(1, 7, 0); drive(1, -3, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
